// File: rtl/fir_pkg.sv
// fir_pkg: shared types, default coefficients and accumulator width helper for fir_filter_param
package fir_pkg;
  localparam int DEF_DATA_W = 7;
  localparam int DEF_COEF_W = 7;
  localparam int DEF_NTAPS = 11;
  typedef logic signed [DEF_DATA_W-1:0] sample_t;
  typedef logic signed [DEF_COEF_W-1:0] coef_t;
  localparam int DEF_COEF [DEF_NTAPS] = '{5, 8, 11, 15, 17, 18, 17, 15, 11, 8, 5};
  function automatic int acc_w(input int dw, input int cw, input int n);
    return dw + cw + $clog2(n);
  endfunction
  function automatic int default_coef(input int k);
    return (k >= 0 && k < DEF_NTAPS) ? DEF_COEF[k] : 0;
  endfunction
endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: NTAPS x COEF_W coefficient registers, reset to defaults, address-checked write port
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int NTAPS = 11,
  parameter int COEF_W = 7,
  parameter int AW = $clog2(NTAPS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [AW-1:0]                addr,
  input  logic [COEF_W-1:0]            wdata,
  output logic [NTAPS-1:0][COEF_W-1:0] coef
);
  // out-of-range addresses match no tap, so they write nothing
  always_ff @(posedge clk)
    for (int k = 0; k < NTAPS; k++)
      if (!rst_n) coef[k] <= COEF_W'(default_coef(k));
      else if (we && addr == AW'(k)) coef[k] <= wdata;
endmodule

// File: rtl/fir_filter_param.sv
// fir_filter_param: parametrised two-stage direct-form FIR; define FIR_SATURATE_EN for clamped output
module fir_filter_param
  import fir_pkg::*;
#(
  parameter int DATA_W = 7,
  parameter int COEF_W = 7,
  parameter int NTAPS = 11,
  parameter int OUT_W = 14
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       out_valid,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       sat_flag
);
  localparam int PW = DATA_W + COEF_W;
  localparam int ACC_W = acc_w(DATA_W, COEF_W, NTAPS);
  logic [NTAPS-1:0][COEF_W-1:0] coef;
  logic signed [DATA_W-1:0] dl [NTAPS-1];
  logic signed [DATA_W-1:0] x [NTAPS];
  logic signed [PW-1:0] p [NTAPS];
  logic v1;
  logic signed [ACC_W-1:0] acc;
  logic signed [OUT_W-1:0] red;
  logic sat;
  fir_coef_bank #(.NTAPS(NTAPS), .COEF_W(COEF_W)) u_coef (
    .clk(clk),
    .rst_n(rst_n),
    .we(coef_we),
    .addr(coef_addr),
    .wdata(coef_data),
    .coef(coef)
  );
  // tap view: current sample followed by the delay line
  always_comb begin
    x[0] = in_data;
    for (int k = 1; k < NTAPS; k++) x[k] = dl[k-1];
  end
  // delay line shifts only on valid samples
  always_ff @(posedge clk)
    for (int k = 0; k < NTAPS-1; k++)
      if (!rst_n) dl[k] <= '0;
      else if (in_valid) dl[k] <= x[k];
  // stage 1: per-tap products with the coefficients in force before any same-cycle write
  always_ff @(posedge clk)
    if (!rst_n) begin
      v1 <= 1'b0;
      for (int k = 0; k < NTAPS; k++) p[k] <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid)
        for (int k = 0; k < NTAPS; k++) p[k] <= PW'(x[k]) * PW'($signed(coef[k]));
    end
  // full-precision sum of the registered products
  always_comb begin
    acc = '0;
    for (int k = 0; k < NTAPS; k++) acc = acc + ACC_W'(p[k]);
  end
  if (OUT_W >= ACC_W) begin : g_ext
    assign red = OUT_W'(acc);
    assign sat = 1'b0;
  end else begin : g_red
`ifdef FIR_SATURATE_EN
    logic [ACC_W-OUT_W:0] hi;
    assign hi = acc[ACC_W-1:OUT_W-1];
    assign sat = !(&hi || ~|hi);
    assign red = sat ? {acc[ACC_W-1], {(OUT_W-1){~acc[ACC_W-1]}}} : acc[OUT_W-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^acc[ACC_W-1:OUT_W];
    assign red = acc[OUT_W-1:0];
    assign sat = 1'b0;
`endif
  end
  // stage 2: register reduced result; data holds between valid outputs
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      sat_flag <= 1'b0;
    end else begin
      out_valid <= v1;
      sat_flag <= v1 & sat;
      if (v1) out_data <= red;
    end
endmodule
